ysyx_25020047_lsu_sram: RTL and testbench

//  Memory responder on the far end of the LSU data-memory interface. Accepts one

---
 rtl/ysyx_25020047_lsu_sram_if.sv | 46 ++++
 rtl/ysyx_25020047_lsu_sram.sv | 173 +++++++++++++++++
 tb/tb_ysyx_25020047_lsu_sram.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_25020047_lsu_sram_if.sv
// LSU data-memory bus between the load/store unit (master) and the SRAM
// responder (slave). One request channel and one response channel, each
// carrying its own valid/ready handshake.
interface ysyx_25020047_lsu_sram_if;

    // request channel, LSU -> memory
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;

    // response channel, memory -> LSU
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid,
        input  req_ready,
        output req_we,
        output req_addr,
        output req_wdata,
        output req_wmask,
        input  resp_valid,
        output resp_ready,
        input  resp_rdata,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  req_wmask,
        output resp_valid,
        input  resp_ready,
        output resp_rdata,
        output resp_err
    );

endinterface

// File: rtl/ysyx_25020047_lsu_sram.sv
// Word-addressed SRAM responder for the LSU data-memory bus.
// It accepts one request at a time in IDLE, waits a fixed latency in WAIT,
// performs the storage access in ACCESS, and then holds the response in RESP
// until the LSU takes it.
//
// Optional feature, macro YSYX_25020047_SRAM_RAND_LAT_EN:
//   when defined, a 16-bit Fibonacci LFSR adds 0..3 extra wait cycles per
//   request so the LSU sees a varying memory latency.
module ysyx_25020047_lsu_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input logic                      clk,
    input logic                      rst_n,
    ysyx_25020047_lsu_sram_if.slave  bus
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [4:0]  LAT_BASE  = 5'(LATENCY);
    localparam logic [29:0] BASE_WORD = ADDR_BASE[31:2];
    localparam logic [29:0] DEPTH_30  = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // latched request; byte-offset bits are dropped because the LSU pre-aligns lanes
    logic        we_q;
    logic [29:0] word_addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;
    logic [4:0]  cnt_q;

    // registered response
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        accept;
    logic        resp_done;
    logic [4:0]  lat_load;

    logic [29:0]      word_off;
    logic             in_range;
    logic [IDX_W-1:0] idx;

    logic [31:0] mem [0:DEPTH_WORDS-1];

    assign accept    = (state == IDLE) && bus.req_valid;
    assign resp_done = (state == RESP) && bus.resp_ready;

`ifdef YSYX_25020047_SRAM_RAND_LAT_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    // taps 16,14,13,11 in 1-based numbering
    assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lat_load = {3'b000, lfsr_q[1:0]} + LAT_BASE;

    // LFSR steps once per accepted request, after its low bits were used
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else if (accept) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end
`else
    assign lat_load = LAT_BASE;
`endif

    // an address below the base wraps on subtraction, so it is rejected explicitly
    assign word_off = word_addr_q - BASE_WORD;
    assign in_range = (word_addr_q >= BASE_WORD) && (word_off < DEPTH_30);
    assign idx      = word_off[IDX_W-1:0];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state; a zero latency skips WAIT entirely
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (lat_load == 5'd0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q <= 5'd1) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                state_next = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // request capture and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            word_addr_q <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            cnt_q       <= '0;
        end else if (accept) begin
            we_q        <= bus.req_we;
            word_addr_q <= bus.req_addr[31:2];
            wdata_q     <= bus.req_wdata;
            wmask_q     <= bus.req_wmask;
            cnt_q       <= lat_load;
        end else if (state == WAIT) begin
            cnt_q <= cnt_q - 5'd1;
        end
    end

    // response registers: loaded in ACCESS, held through RESP, cleared on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else if (state == ACCESS) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= !in_range;
            resp_rdata_q <= (in_range && !we_q) ? mem[idx] : 32'h0;
        end else if (resp_done) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end
    end

    // storage write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (state == ACCESS && we_q && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_ysyx_25020047_lsu_sram.sv
// Directed testbench for ysyx_25020047_lsu_sram (LATENCY=2, DEPTH_WORDS=1024).
module tb_ysyx_25020047_lsu_sram;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ysyx_25020047_lsu_sram_if bus ();

    ysyx_25020047_lsu_sram #(
        .ADDR_BASE  (32'h8000_0000),
        .DEPTH_WORDS(1024),
        .LATENCY    (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // present a request and return 1ns after the accepting edge
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wmask);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wmask = wmask;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // count edges after acceptance until resp_valid appears; 99 means timeout
    task automatic waitResp(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.resp_valid) break;
        end
        if (!bus.resp_valid) lat = 99;
    endtask

    task automatic finishResp();
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic transact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wmask, output logic [31:0] rdata,
                            output logic err, output int lat);
        applyStimulus(we, addr, wdata, wmask);
        waitResp(lat);
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        finishResp();
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_wmask  = '0;
        bus.resp_ready = 1'b0;

        // reset held for three cycles
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("rst_resp_err",   32'(bus.resp_err),   32'd0);
        checkOutput("rst_resp_rdata", bus.resp_rdata,      32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_req_ready",  32'(bus.req_ready),  32'd1);

        // full-word write then read back
        transact(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        checkOutput("wr_latency", 32'(lat), 32'd3);
        checkOutput("wr_err",     32'(er),  32'd0);
        checkOutput("wr_rdata",   rd,       32'h0);
        transact(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
        checkOutput("rd_latency", 32'(lat), 32'd3);
        checkOutput("rd_err",     32'(er),  32'd0);
        checkOutput("rd_rdata",   rd,       32'hDEAD_BEEF);

        // single byte lane 2
        transact(1'b1, 32'h8000_0012, 32'h00AB_0000, 4'h4, rd, er, lat);
        transact(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
        checkOutput("sb_rdata", rd, 32'hDEAB_BEEF);

        // empty mask: response still produced, word untouched
        transact(1'b1, 32'h8000_0010, 32'h1234_5678, 4'h0, rd, er, lat);
        checkOutput("m0_latency", 32'(lat), 32'd3);
        transact(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
        checkOutput("m0_rdata", rd, 32'hDEAB_BEEF);

        // back-pressure on the response channel
        applyStimulus(1'b0, 32'h8000_0010, 32'h0, 4'h0);
        checkOutput("bp_busy_ready", 32'(bus.req_ready), 32'd0);
        waitResp(lat);
        checkOutput("bp_latency", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_hold_valid", 32'(bus.resp_valid), 32'd1);
            checkOutput("bp_hold_rdata", bus.resp_rdata,      32'hDEAB_BEEF);
            checkOutput("bp_hold_ready", 32'(bus.req_ready),  32'd0);
            @(posedge clk);
            #1;
        end
        finishResp();
        checkOutput("bp_rel_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("bp_rel_ready", 32'(bus.req_ready),  32'd1);

        // range boundaries
        transact(1'b1, 32'h8000_0000, 32'hA5A5_0001, 4'hF, rd, er, lat);
        transact(1'b1, 32'h8000_0FFC, 32'h0BAD_F00D, 4'hF, rd, er, lat);
        checkOutput("last_wr_err", 32'(er), 32'd0);
        transact(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, rd, er, lat);
        checkOutput("low_err",   32'(er), 32'd1);
        checkOutput("low_rdata", rd,      32'h0);
        transact(1'b0, 32'h8000_1000, 32'h0, 4'h0, rd, er, lat);
        checkOutput("high_err",   32'(er), 32'd1);
        checkOutput("high_rdata", rd,      32'h0);
        transact(1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
        checkOutput("high_wr_err", 32'(er), 32'd1);
        transact(1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
        checkOutput("low_wr_err", 32'(er), 32'd1);
        transact(1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat);
        checkOutput("w0_intact", rd, 32'hA5A5_0001);
        transact(1'b0, 32'h8000_0FFC, 32'h0, 4'h0, rd, er, lat);
        checkOutput("last_rd_err",   32'(er), 32'd0);
        checkOutput("last_rd_rdata", rd,      32'h0BAD_F00D);

        // reset during WAIT drops an uncommitted write
        transact(1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, rd, er, lat);
        applyStimulus(1'b1, 32'h8000_0020, 32'h5566_7788, 4'hF);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(bus.resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checkOutput("arst_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        transact(1'b0, 32'h8000_0020, 32'h0, 4'h0, rd, er, lat);
        checkOutput("arst_latency", 32'(lat), 32'd3);
        checkOutput("arst_rdata",   rd,       32'h1122_3344);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
